// File: rtl/fb_scanout.sv
// Display scanout: raster counters, upscaled framebuffer addressing, CLUT lookup and
// delay-matched sync/de. Buffer swaps are applied only at the start of a frame.
module fb_scanout #(
    parameter int   H_ACTIVE      = 640,
    parameter int   H_FP          = 16,
    parameter int   H_SYNC        = 96,
    parameter int   H_BP          = 48,
    parameter int   V_ACTIVE      = 480,
    parameter int   V_FP          = 10,
    parameter int   V_SYNC        = 2,
    parameter int   V_BP          = 33,
    parameter logic SYNC_POL      = 1'b0,
    parameter int   SCALE         = 2,
    parameter int   INDEX_WIDTH   = 8,
    parameter int   COLOR_WIDTH   = 12,
    localparam int  FB_W          = H_ACTIVE / SCALE,
    localparam int  FB_H          = V_ACTIVE / SCALE,
    localparam int  FB_ADDR_WIDTH = $clog2(FB_W * FB_H)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     swap_req,
    output logic                     swap_ack,
    output logic                     fb_sel,
    output logic [FB_ADDR_WIDTH-1:0] fb_addr,
    input  logic [INDEX_WIDTH-1:0]   fb_index,
    output logic [INDEX_WIDTH-1:0]   clut_addr,
    input  logic [COLOR_WIDTH-1:0]   clut_color,
    output logic                     frame_start,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     de,
    output logic [COLOR_WIDTH-1:0]   rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL + 1);
    localparam int V_W     = $clog2(V_TOTAL + 1);
    localparam int COL_W   = $clog2(FB_W + 1);
    localparam int SUB_W   = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_ROW_LAST = V_W'(V_ACTIVE - 1);
    localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SUB_W-1:0] S_LAST = SUB_W'(SCALE - 1);
    localparam logic [FB_ADDR_WIDTH-1:0] FB_W_A = FB_ADDR_WIDTH'(FB_W);

    logic [H_W-1:0]           h_q;
    logic [V_W-1:0]           v_q;
    logic [SUB_W-1:0]         hsub_q, vsub_q;
    logic [COL_W-1:0]         col_q;
    logic [FB_ADDR_WIDTH-1:0] row_q;
    logic                     pend_q;
    logic                     act_p1_q, act_p2_q, act_p3_q;
    logic                     hs_p1_q, hs_p2_q, hs_p3_q;
    logic                     vs_p1_q, vs_p2_q, vs_p3_q;

    logic                     active_d, hreg_d, vreg_d, sof_d, take_swap_d;
    logic [FB_ADDR_WIDTH-1:0] addr_d;

    always_comb begin
        active_d    = (h_q < H_ACT) && (v_q < V_ACT);
        hreg_d      = (h_q >= HS_BEG) && (h_q < HS_END);
        vreg_d      = (v_q >= VS_BEG) && (v_q < VS_END);
        sof_d       = (h_q == '0) && (v_q == '0);
        take_swap_d = sof_d && (pend_q || swap_req);
        addr_d      = row_q + FB_ADDR_WIDTH'(col_q);
    end

    // Stage p0: raster counters; col/row track h/SCALE and (v/SCALE)*FB_W incrementally
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q    <= '0;
            v_q    <= '0;
            hsub_q <= '0;
            vsub_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
        end else if (h_q == H_LAST) begin
            h_q    <= '0;
            hsub_q <= '0;
            col_q  <= '0;
            if (v_q == V_LAST) begin
                v_q    <= '0;
                vsub_q <= '0;
                row_q  <= '0;
            end else begin
                v_q <= v_q + 1'b1;
                if (v_q < V_ACT) begin
                    if (vsub_q == S_LAST) begin
                        vsub_q <= '0;
                        if (v_q != V_ROW_LAST)
                            row_q <= row_q + FB_W_A;
                    end else begin
                        vsub_q <= vsub_q + 1'b1;
                    end
                end
            end
        end else begin
            h_q <= h_q + 1'b1;
            if (h_q < H_ACT) begin
                if (hsub_q == S_LAST) begin
                    hsub_q <= '0;
                    col_q  <= col_q + 1'b1;
                end else begin
                    hsub_q <= hsub_q + 1'b1;
                end
            end
        end
    end

    // Stage p1: address, buffer select and frame/swap pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_addr     <= '0;
            fb_sel      <= 1'b0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            pend_q      <= 1'b0;
            act_p1_q    <= 1'b0;
            hs_p1_q     <= 1'b0;
            vs_p1_q     <= 1'b0;
        end else begin
            if (active_d)
                fb_addr <= addr_d;
            if (take_swap_d)
                fb_sel <= ~fb_sel;
            swap_ack    <= take_swap_d;
            frame_start <= sof_d;
            pend_q      <= (pend_q | swap_req) & ~sof_d;
            act_p1_q    <= active_d;
            hs_p1_q     <= hreg_d;
            vs_p1_q     <= vreg_d;
        end
    end

    // Stage p2/p3: fb_index then clut_color arrive; timing bits follow along
    assign clut_addr = fb_index;

    always_ff @(posedge clk) begin
        if (rst) begin
            act_p2_q <= 1'b0;
            act_p3_q <= 1'b0;
            hs_p2_q  <= 1'b0;
            hs_p3_q  <= 1'b0;
            vs_p2_q  <= 1'b0;
            vs_p3_q  <= 1'b0;
        end else begin
            act_p2_q <= act_p1_q;
            act_p3_q <= act_p2_q;
            hs_p2_q  <= hs_p1_q;
            hs_p3_q  <= hs_p2_q;
            vs_p2_q  <= vs_p1_q;
            vs_p3_q  <= vs_p2_q;
        end
    end

    // Stage p4: registered pixel outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            de    <= 1'b0;
            rgb   <= '0;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
        end else begin
            de    <= act_p3_q;
            rgb   <= act_p3_q ? clut_color : '0;
            hsync <= hs_p3_q ? SYNC_POL : ~SYNC_POL;
            vsync <= vs_p3_q ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout on a 14x7 raster, SCALE=2, with a 1-cycle framebuffer and CLUT model.
module tb_fb_scanout;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        swap_req = 1'b0;
    logic        swap_ack, fb_sel, frame_start, hsync, vsync, de;
    logic [3:0]  fb_addr;
    logic [7:0]  fb_index = 8'd0;
    logic [7:0]  clut_addr;
    logic [11:0] clut_color = 12'd0;
    logic [11:0] rgb;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    fb_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .SCALE(2), .INDEX_WIDTH(8), .COLOR_WIDTH(12)
    ) dut (
        .clk(clk), .rst(rst), .swap_req(swap_req), .swap_ack(swap_ack),
        .fb_sel(fb_sel), .fb_addr(fb_addr), .fb_index(fb_index),
        .clut_addr(clut_addr), .clut_color(clut_color), .frame_start(frame_start),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb)
    );

    always #5 clk = ~clk;

    // Framebuffer: index = addr + 16*fb_sel, one cycle later. CLUT: colour = index*0x011.
    always @(posedge clk) fb_index <= {4'b0, fb_addr} + (fb_sel ? 8'd16 : 8'd0);
    always @(posedge clk) clut_color <= {4'b0, clut_addr} * 12'h011;

    typedef struct {
        int cyc;
        bit swp;
        bit de;
        bit hs;
        bit vs;
        int rgb;
        int fa;
        bit fs;
        bit ack;
        bit sel;
    } vec_t;

    vec_t vecs[$];

    task automatic goto(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    task automatic add(input int c, input bit s, input bit d, input bit h, input bit v,
                       input int r, input int a, input bit f, input bit k, input bit l);
        vec_t t;
        t.cyc = c; t.swp = s; t.de = d; t.hs = h; t.vs = v;
        t.rgb = r; t.fa = a; t.fs = f; t.ack = k; t.sel = l;
        vecs.push_back(t);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        swap_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        //   cyc swp de hs vs rgb     fa fs ack sel
        add(  0, 0, 0, 1, 1, 12'h000, 0, 0, 0, 0);
        add(  1, 0, 0, 1, 1, 12'h000, 0, 1, 0, 0);
        add(  2, 0, 0, 1, 1, 12'h000, 0, 0, 0, 0);
        add(  3, 0, 0, 1, 1, 12'h000, 1, 0, 0, 0);
        add(  4, 0, 1, 1, 1, 12'h000, 1, 0, 0, 0);
        add(  6, 0, 1, 1, 1, 12'h011, 2, 0, 0, 0);
        add(  8, 0, 1, 1, 1, 12'h022, 3, 0, 0, 0);
        add( 11, 0, 1, 1, 1, 12'h033, 3, 0, 0, 0);
        add( 12, 0, 0, 1, 1, 12'h000, 3, 0, 0, 0);
        add( 14, 0, 0, 0, 1, 12'h000, 3, 0, 0, 0);
        add( 15, 0, 0, 0, 1, 12'h000, 0, 0, 0, 0);
        add( 16, 0, 0, 1, 1, 12'h000, 0, 0, 0, 0);
        add( 18, 0, 1, 1, 1, 12'h000, 1, 0, 0, 0);
        add( 20, 1, 1, 1, 1, 12'h011, 2, 0, 0, 0);
        add( 21, 0, 1, 1, 1, 12'h011, 3, 0, 0, 0);
        add( 29, 0, 0, 0, 1, 12'h000, 4, 0, 0, 0);
        add( 30, 1, 0, 1, 1, 12'h000, 4, 0, 0, 0);
        add( 31, 0, 0, 1, 1, 12'h000, 5, 0, 0, 0);
        add( 32, 0, 1, 1, 1, 12'h044, 5, 0, 0, 0);
        add( 34, 0, 1, 1, 1, 12'h055, 6, 0, 0, 0);
        add( 46, 0, 1, 1, 1, 12'h044, 5, 0, 0, 0);
        add( 53, 0, 1, 1, 1, 12'h077, 7, 0, 0, 0);
        add( 60, 0, 0, 1, 1, 12'h000, 7, 0, 0, 0);
        add( 70, 0, 0, 0, 1, 12'h000, 7, 0, 0, 0);
        add( 73, 0, 0, 1, 1, 12'h000, 7, 0, 0, 0);
        add( 74, 0, 0, 1, 0, 12'h000, 7, 0, 0, 0);
        add( 84, 0, 0, 0, 0, 12'h000, 7, 0, 0, 0);
        add( 87, 0, 0, 1, 0, 12'h000, 7, 0, 0, 0);
        add( 88, 0, 0, 1, 1, 12'h000, 7, 0, 0, 0);
        add( 98, 0, 0, 0, 1, 12'h000, 7, 0, 0, 0);
        add( 99, 0, 0, 0, 1, 12'h000, 0, 1, 1, 1);
        add(100, 0, 0, 1, 1, 12'h000, 0, 0, 0, 1);
        add(102, 0, 1, 1, 1, 12'h110, 1, 0, 0, 1);
        add(104, 0, 1, 1, 1, 12'h121, 2, 0, 0, 1);
        add(109, 0, 1, 1, 1, 12'h143, 3, 0, 0, 1);
        add(112, 0, 0, 0, 1, 12'h000, 3, 0, 0, 1);
        add(196, 0, 0, 0, 1, 12'h000, 7, 0, 0, 1);
        add(197, 0, 0, 0, 1, 12'h000, 0, 1, 0, 1);

        do_reset();
        foreach (vecs[i]) begin
            goto(vecs[i].cyc);
            swap_req = vecs[i].swp;
            chk("de", {31'b0, de}, {31'b0, vecs[i].de});
            chk("hsync", {31'b0, hsync}, {31'b0, vecs[i].hs});
            chk("vsync", {31'b0, vsync}, {31'b0, vecs[i].vs});
            chk("rgb", {20'b0, rgb}, vecs[i].rgb);
            chk("fb_addr", {28'b0, fb_addr}, vecs[i].fa);
            chk("frame_start", {31'b0, frame_start}, {31'b0, vecs[i].fs});
            chk("swap_ack", {31'b0, swap_ack}, {31'b0, vecs[i].ack});
            chk("fb_sel", {31'b0, fb_sel}, {31'b0, vecs[i].sel});
        end
        swap_req = 1'b0;

        // Swap requests right at the frame boundary
        do_reset();
        goto(98);
        chk("bnd_ack_98", {31'b0, swap_ack}, 0);
        chk("bnd_sel_98", {31'b0, fb_sel}, 0);
        swap_req = 1'b1;
        goto(99);
        chk("bnd_ack_99", {31'b0, swap_ack}, 1);
        chk("bnd_fs_99", {31'b0, frame_start}, 1);
        chk("bnd_sel_99", {31'b0, fb_sel}, 1);
        goto(100);
        swap_req = 1'b0;
        chk("bnd_ack_100", {31'b0, swap_ack}, 0);
        chk("bnd_sel_100", {31'b0, fb_sel}, 1);
        goto(196);
        chk("bnd_ack_196", {31'b0, swap_ack}, 0);
        chk("bnd_sel_196", {31'b0, fb_sel}, 1);
        goto(197);
        chk("bnd_ack_197", {31'b0, swap_ack}, 1);
        chk("bnd_fs_197", {31'b0, frame_start}, 1);
        chk("bnd_sel_197", {31'b0, fb_sel}, 0);

        // Get fb_sel=1 with another swap pending, then reset mid-frame
        goto(200);
        swap_req = 1'b1;
        goto(201);
        swap_req = 1'b0;
        goto(295);
        chk("pre_ack_295", {31'b0, swap_ack}, 1);
        chk("pre_sel_295", {31'b0, fb_sel}, 1);
        goto(300);
        swap_req = 1'b1;
        goto(301);
        swap_req = 1'b0;
        goto(340);
        chk("pre_de_340", {31'b0, de}, 1);
        chk("pre_rgb_340", {20'b0, rgb}, 12'h154);
        rst = 1'b1;
        goto(341);
        chk("rst_de", {31'b0, de}, 0);
        chk("rst_rgb", {20'b0, rgb}, 0);
        chk("rst_hsync", {31'b0, hsync}, 1);
        chk("rst_vsync", {31'b0, vsync}, 1);
        chk("rst_fb_addr", {28'b0, fb_addr}, 0);
        chk("rst_fb_sel", {31'b0, fb_sel}, 0);
        chk("rst_ack", {31'b0, swap_ack}, 0);
        chk("rst_fs", {31'b0, frame_start}, 0);
        goto(343);
        rst = 1'b0;
        cyc = 0;
        for (int c = 0; c <= 100; c++) begin
            goto(c);
            chk("post_ack", {31'b0, swap_ack}, 0);
            chk("post_sel", {31'b0, fb_sel}, 0);
            if (c < 4) begin
                chk("post_de", {31'b0, de}, 0);
                chk("post_hsync", {31'b0, hsync}, 1);
                chk("post_vsync", {31'b0, vsync}, 1);
            end
            if (c == 1 || c == 99)
                chk("post_fs", {31'b0, frame_start}, 1);
            if (c == 4) begin
                chk("post_de4", {31'b0, de}, 1);
                chk("post_rgb4", {20'b0, rgb}, 12'h000);
            end
            if (c == 6)
                chk("post_rgb6", {20'b0, rgb}, 12'h011);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
